// File: rtl/ccff_bitstream_loader.sv
// Serialises a byte stream onto the configuration flip-flop chain head, one bit per enabled cycle.
// Build option CCFF_LOADER_READBACK_CRC_EN adds a CRC-16-CCITT over the bits leaving the chain tail.
module ccff_bitstream_loader #(
   parameter int unsigned CHAIN_LEN = 1024,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic        prog_clk,
   input  logic        prog_reset,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        ccff_head,
   input  logic        ccff_tail,
   output logic        cfg_clk_en,
   output logic        busy,
   output logic        done,
   output logic [15:0] bits_sent,
   output logic [15:0] readback_crc
);

   localparam int unsigned      CNT_W     = 16;
   localparam int unsigned      IDX_W     = 3;
   localparam int unsigned      NBYTES    = (CHAIN_LEN + 7) / 8;
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        shift_q, shift_d;
   logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic              sh_full_q, sh_full_d;
   logic [7:0]        hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic [CNT_W-1:0]  bytes_q, bytes_d;
   logic [CNT_W-1:0]  bits_q, bits_d;
   logic              head_q, head_d;
   logic              en_q, en_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [7:0]        src_byte;
   logic              src_bit;
   logic [7:0]        src_shifted;
   logic              bit_avail;
   logic              accept;

   // Bit source: the shifter when it holds a byte, otherwise the holding register (load-and-emit).
   always_comb begin
      src_byte    = sh_full_q ? shift_q : hold_q;
      src_bit     = MSB_FIRST ? src_byte[7] : src_byte[0];
      src_shifted = MSB_FIRST ? {src_byte[6:0], 1'b0} : {1'b0, src_byte[7:1]};
      bit_avail   = sh_full_q || hold_full_q;
      accept      = in_valid && ready_q;
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_idx_d   = bit_idx_q;
      sh_full_d   = sh_full_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bytes_d     = bytes_q;
      bits_d      = bits_q;
      head_d      = head_q;
      en_d        = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_RUN;
               sh_full_d   = 1'b0;
               bit_idx_d   = '0;
               hold_full_d = 1'b0;
               bytes_d     = '0;
               bits_d      = '0;
            end
         end
         ST_RUN: begin
            if (bits_q == LAST_BIT) begin
               // Chain full: leftover bits of the final byte are dropped.
               state_d     = ST_DONE;
               sh_full_d   = 1'b0;
               hold_full_d = 1'b0;
               bit_idx_d   = '0;
            end else if (bit_avail) begin
               head_d  = src_bit;
               en_d    = 1'b1;
               bits_d  = bits_q + CNT_W'(1);
               shift_d = src_shifted;
               if (sh_full_q) begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
                  if (bit_idx_q == IDX_W'(7)) begin
                     sh_full_d = 1'b0;
                  end
               end else begin
                  bit_idx_d   = IDX_W'(1);
                  sh_full_d   = 1'b1;
                  hold_full_d = 1'b0;
               end
            end
            if (accept) begin
               hold_d      = in_data;
               hold_full_d = 1'b1;
               bytes_d     = bytes_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort dominates start; counters are frozen for inspection.
      if (abort) begin
         state_d     = ST_IDLE;
         sh_full_d   = 1'b0;
         hold_full_d = 1'b0;
         bit_idx_d   = '0;
         en_d        = 1'b0;
         head_d      = head_q;
         bits_d      = bits_q;
         bytes_d     = bytes_q;
      end
   end

   // Status outputs are registered from the next state.
   always_comb begin
      ready_d = (state_d == ST_RUN) && !hold_full_d && (bytes_d < LAST_BYTE);
      busy_d  = (state_d == ST_RUN);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_idx_q   <= '0;
         sh_full_q   <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bytes_q     <= '0;
         bits_q      <= '0;
         head_q      <= 1'b0;
         en_q        <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_idx_q   <= bit_idx_d;
         sh_full_q   <= sh_full_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bytes_q     <= bytes_d;
         bits_q      <= bits_d;
         head_q      <= head_d;
         en_q        <= en_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready   = ready_q;
   assign ccff_head  = head_q;
   assign cfg_clk_en = en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign bits_sent  = bits_q;

`ifdef CCFF_LOADER_READBACK_CRC_EN
   logic [15:0] crc_q, crc_d;
   logic        start_load;

   // Tail bit is folded in on every cycle the chain is clocked.
   always_comb begin
      start_load = start && !abort && (state_q != ST_RUN);
      crc_d      = crc_q;
      if (start_load) begin
         crc_d = 16'hFFFF;
      end else if (en_q) begin
         crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ ccff_tail) ? 16'h1021 : 16'h0000);
      end
   end

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign readback_crc = crc_q;
`else
   logic unused_tail;
   assign unused_tail  = ccff_tail;
   assign readback_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader: two instances (MSB-first 12-bit chain, LSB-first 8-bit chain).
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;

   localparam int unsigned LEN_A = 12;
   localparam int unsigned LEN_B = 8;

   typedef struct {
      logic        head;
      int unsigned cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        prog_reset;
   logic        start_s    [2];
   logic        abort_s    [2];
   logic [7:0]  in_data_s  [2];
   logic        in_valid_s [2];
   logic        tail_s     [2];
   logic        in_ready_s [2];
   logic        head_s     [2];
   logic        en_s       [2];
   logic        busy_s     [2];
   logic        done_s     [2];
   logic [15:0] bits_s     [2];
   logic [15:0] crc_s      [2];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   bit          tail_zero = 1'b0;

   exp_t        exp_a [$];
   exp_t        exp_b [$];
   int unsigned pushed    [2];
   int unsigned acc_cnt   [2];
   int          acc_first [2];
   int          first_en  [2];
   int          last_en   [2];
   int unsigned en_cnt    [2];
   logic [31:0] seq       [2];
   logic [15:0] crc_m     [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ccff_bitstream_loader #(.CHAIN_LEN(LEN_A), .MSB_FIRST(1'b1)) u_dut_a (
      .prog_clk(clk), .prog_reset(prog_reset), .start(start_s[0]), .abort(abort_s[0]),
      .in_data(in_data_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
      .ccff_head(head_s[0]), .ccff_tail(tail_s[0]), .cfg_clk_en(en_s[0]), .busy(busy_s[0]),
      .done(done_s[0]), .bits_sent(bits_s[0]), .readback_crc(crc_s[0]));

   ccff_bitstream_loader #(.CHAIN_LEN(LEN_B), .MSB_FIRST(1'b0)) u_dut_b (
      .prog_clk(clk), .prog_reset(prog_reset), .start(start_s[1]), .abort(abort_s[1]),
      .in_data(in_data_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
      .ccff_head(head_s[1]), .ccff_tail(tail_s[1]), .cfg_clk_en(en_s[1]), .busy(busy_s[1]),
      .done(done_s[1]), .bits_sent(bits_s[1]), .readback_crc(crc_s[1]));

   function automatic int unsigned len_of(input int d);
      return (d == 0) ? LEN_A : LEN_B;
   endfunction

   function automatic bit msb_of(input int d);
      return (d == 0);
   endfunction

   function automatic int unsigned nbytes_of(input int d);
      return (len_of(d) + 7) / 8;
   endfunction

   // CRC-16-CCITT reference, one message bit at a time (MSB-first division by x^16+x^12+x^5+1).
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic [16:0] t;
      t = {c, 1'b0};
      if (c[15] ^ b) t = t ^ 17'h11021;
      return t[15:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] crc_expected(input int d);
`ifdef CCFF_LOADER_READBACK_CRC_EN
      return crc_m[d];
`else
      return (d < 0) ? crc_m[0] : 16'h0000;
`endif
   endfunction

   task automatic reset_model(input int d);
      if (d == 0) exp_a.delete(); else exp_b.delete();
      pushed[d]    = 0;
      acc_cnt[d]   = 0;
      acc_first[d] = -1;
      first_en[d]  = -1;
      last_en[d]   = -1;
      en_cnt[d]    = 0;
      seq[d]       = '0;
      crc_m[d]     = 16'hFFFF;
   endtask

   // Expected chain bits for an accepted byte, truncated at the chain length.
   task automatic push_exp(input int d, input logic [7:0] b);
      exp_t e;
      for (int k = 0; k < 8; k++) begin
         if (pushed[d] < len_of(d)) begin
            pushed[d]++;
            e.head = msb_of(d) ? b[7-k] : b[k];
            e.cnt  = pushed[d];
            if (d == 0) exp_a.push_back(e); else exp_b.push_back(e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int d);
      start_s[d] = 1'b1;
      tick();
      start_s[d] = 1'b0;
      reset_model(d);
      @(negedge clk);
      check($sformatf("start_busy_d%0d", d), 32'(busy_s[d]), 32'd1);
      check($sformatf("start_ready_d%0d", d), 32'(in_ready_s[d]), 32'd1);
      check($sformatf("start_bits_d%0d", d), 32'(bits_s[d]), 32'd0);
      check($sformatf("start_done_d%0d", d), 32'(done_s[d]), 32'd0);
      tick();
   endtask

   task automatic feed_byte(input int d, input logic [7:0] b, input int pre, input int maxw, output bit ok);
      logic r;
      repeat (pre) tick();
      in_data_s[d]  = b;
      in_valid_s[d] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < maxw && !ok; i++) begin
         @(negedge clk);
         r = in_ready_s[d];
         tick();
         if (r) ok = 1'b1;
      end
      in_valid_s[d] = 1'b0;
      if (ok) begin
         acc_cnt[d]++;
         if (acc_first[d] < 0) acc_first[d] = cyc;
         push_exp(d, b);
      end
   endtask

   task automatic wait_done(input int d, input string tag);
      bit ok;
      int qs;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (done_s[d]) ok = 1'b1;
      end
      qs = (d == 0) ? exp_a.size() : exp_b.size();
      check($sformatf("%s_done", tag), 32'(done_s[d]), 32'd1);
      check($sformatf("%s_busy", tag), 32'(busy_s[d]), 32'd0);
      check($sformatf("%s_ready", tag), 32'(in_ready_s[d]), 32'd0);
      check($sformatf("%s_clk_en", tag), 32'(en_s[d]), 32'd0);
      check($sformatf("%s_bits_sent", tag), 32'(bits_s[d]), 32'(len_of(d)));
      check($sformatf("%s_bytes_accepted", tag), 32'(acc_cnt[d]), 32'(nbytes_of(d)));
      check($sformatf("%s_bits_pending", tag), 32'(qs), 32'd0);
      check($sformatf("%s_done_latency", tag), 32'(cyc), 32'(last_en[d] + 1));
      check($sformatf("%s_first_bit_latency", tag), 32'(first_en[d] - acc_first[d]), 32'd1);
      check($sformatf("%s_crc", tag), 32'(crc_s[d]), 32'(crc_expected(d)));
      tick();
   endtask

   task automatic wait_bits(input int d, input int unsigned n, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (bits_s[d] == 16'(n)) ok = 1'b1;
      end
      check($sformatf("%s_reach_%0d", tag, n), 32'(bits_s[d]), 32'(n));
   endtask

   task automatic rand_load(input int d);
      logic [7:0] b;
      bit ok;
      do_start(d);
      for (int i = 0; i < int'(nbytes_of(d)); i++) begin
         b = 8'($urandom);
         feed_byte(d, b, int'($urandom_range(0, 3)), 200, ok);
         check($sformatf("rand_accept_d%0d", d), 32'(ok), 32'd1);
      end
      wait_done(d, $sformatf("rand_d%0d", d));
   endtask

   // Scoreboard monitor: every enabled chain cycle must match the next expected bit.
   always @(negedge clk) begin
      exp_t e;
      int   qs;
      for (int d = 0; d < 2; d++) begin
         if (!prog_reset && en_s[d]) begin
            qs = (d == 0) ? exp_a.size() : exp_b.size();
            if (qs == 0) begin
               check($sformatf("unexpected_bit_d%0d", d), 32'(en_s[d]), 32'd0);
            end else begin
               if (d == 0) e = exp_a.pop_front(); else e = exp_b.pop_front();
               check($sformatf("head_d%0d_bit%0d", d, e.cnt), 32'(head_s[d]), 32'(e.head));
               check($sformatf("bits_sent_d%0d", d), 32'(bits_s[d]), e.cnt);
            end
            if (first_en[d] < 0) first_en[d] = cyc;
            last_en[d] = cyc;
            en_cnt[d]++;
            seq[d]   = {seq[d][30:0], head_s[d]};
            crc_m[d] = crc_step(crc_m[d], tail_s[d]);
         end
      end
   end

   // Random tail stream, changed just after each rising edge.
   initial begin
      for (int d = 0; d < 2; d++) tail_s[d] = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         for (int d = 0; d < 2; d++) tail_s[d] = tail_zero ? 1'b0 : 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      prog_reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0; abort_s[d] = 1'b0; in_data_s[d] = '0; in_valid_s[d] = 1'b0;
         reset_model(d);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_ready_d%0d", d), 32'(in_ready_s[d]), 32'd0);
         check($sformatf("rst_head_d%0d", d), 32'(head_s[d]), 32'd0);
         check($sformatf("rst_clk_en_d%0d", d), 32'(en_s[d]), 32'd0);
         check($sformatf("rst_busy_d%0d", d), 32'(busy_s[d]), 32'd0);
         check($sformatf("rst_done_d%0d", d), 32'(done_s[d]), 32'd0);
         check($sformatf("rst_bits_d%0d", d), 32'(bits_s[d]), 32'd0);
         check($sformatf("rst_crc_d%0d", d), 32'(crc_s[d]), 32'd0);
      end
      tick();
      prog_reset = 1'b0;
      tick();

      // 12-bit MSB-first chain, two bytes back-to-back
      do_start(0);
      feed_byte(0, 8'hA5, 0, 50, ok);
      check("a_accept0", 32'(ok), 32'd1);
      feed_byte(0, 8'h3C, 0, 50, ok);
      check("a_accept1", 32'(ok), 32'd1);
      wait_done(0, "a_basic");
      check("a_head_sequence", seq[0], 32'h0000_0A53);
      check("a_no_gaps", 32'(last_en[0] - first_en[0] + 1), 32'd12);
      feed_byte(0, 8'hFF, 0, 10, ok);
      check("a_extra_byte_refused", 32'(ok), 32'd0);

      // 8-bit LSB-first chain with a zero tail
      tail_zero = 1'b1;
      tick();
      do_start(1);
      feed_byte(1, 8'h01, 0, 50, ok);
      check("b_accept", 32'(ok), 32'd1);
      wait_done(1, "b_basic");
      check("b_head_sequence", seq[1], 32'h0000_0080);
`ifdef CCFF_LOADER_READBACK_CRC_EN
      check("b_crc_zero_tail", 32'(crc_s[1]), 32'h0000_E1F0);
`else
      check("b_crc_disabled", 32'(crc_s[1]), 32'h0000_0000);
`endif
      tail_zero = 1'b0;

      // Underrun between bytes
      do_start(0);
      feed_byte(0, 8'hC3, 0, 50, ok);
      check("ur_accept0", 32'(ok), 32'd1);
      wait_bits(0, 8, "ur");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("ur_gap_clk_en", 32'(en_s[0]), 32'd0);
         check("ur_gap_bits", 32'(bits_s[0]), 32'd8);
      end
      tick();
      feed_byte(0, 8'h5A, 0, 50, ok);
      check("ur_accept1", 32'(ok), 32'd1);
      wait_done(0, "ur");

      // Abort at five bits
      do_start(0);
      feed_byte(0, 8'h96, 0, 50, ok);
      wait_bits(0, 5, "ab");
      abort_s[0] = 1'b1;
      @(posedge clk);
      #1;
      abort_s[0] = 1'b0;
      @(negedge clk);
      check("ab_busy", 32'(busy_s[0]), 32'd0);
      check("ab_done", 32'(done_s[0]), 32'd0);
      check("ab_bits_held", 32'(bits_s[0]), 32'd5);
      check("ab_ready", 32'(in_ready_s[0]), 32'd0);
      check("ab_clk_en", 32'(en_s[0]), 32'd0);
      check("ab_crc_held", 32'(crc_s[0]), 32'(crc_expected(0)));
      exp_a.delete();
      tick();
      start_s[0] = 1'b1;
      abort_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      abort_s[0] = 1'b0;
      @(negedge clk);
      check("ab_abort_beats_start", 32'(busy_s[0]), 32'd0);
      check("ab_bits_still_held", 32'(bits_s[0]), 32'd5);
      tick();
      do_start(0);
      feed_byte(0, 8'h0F, 0, 50, ok);
      start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      feed_byte(0, 8'hF0, 0, 50, ok);
      wait_done(0, "ab_restart");

      // Asynchronous reset in the middle of a load
      do_start(0);
      feed_byte(0, 8'hE7, 0, 50, ok);
      wait_bits(0, 3, "rs");
      #1;
      prog_reset = 1'b1;
      #1;
      check("rs_ready", 32'(in_ready_s[0]), 32'd0);
      check("rs_head", 32'(head_s[0]), 32'd0);
      check("rs_clk_en", 32'(en_s[0]), 32'd0);
      check("rs_busy", 32'(busy_s[0]), 32'd0);
      check("rs_done", 32'(done_s[0]), 32'd0);
      check("rs_bits", 32'(bits_s[0]), 32'd0);
      check("rs_crc", 32'(crc_s[0]), 32'd0);
      start_s[0] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rs_start_ignored", 32'(busy_s[0]), 32'd0);
      start_s[0] = 1'b0;
      tick();
      prog_reset = 1'b0;
      reset_model(0);
      @(negedge clk);
      check("rs_idle_after_release", 32'(busy_s[0]), 32'd0);
      tick();
      rand_load(0);

      // Randomised loads on both chains
      for (int r = 0; r < 12; r++) begin
         rand_load(0);
         rand_load(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
